// File: rtl/load_hazard_tracker.sv
// Load-use hazard unit: in-order FIFO of outstanding load destinations with ID stall,
// EX hold on full FIFO, a saturating stall-cycle counter and a sticky underflow flag.
module load_hazard_tracker #(
   parameter int NUM_SRC   = 3,
   parameter int REG_W     = 5,
   parameter int ZERO_REG  = 31,
   parameter int DEPTH     = 4,
   parameter int CNT_W     = 32,
   localparam int CNT_W_OCC = $clog2(DEPTH + 1)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       id_valid,
   input  logic [NUM_SRC*REG_W-1:0]   id_rs,
   input  logic [NUM_SRC-1:0]         id_rs_used,
   input  logic                       ex_load_valid,
   input  logic [REG_W-1:0]           ex_rd,
   input  logic                       ex_advance,
   input  logic                       mem_resp_valid,
   output logic                       stall,
   output logic                       ex_hold,
   output logic [CNT_W_OCC-1:0]       pending_cnt,
   output logic [CNT_W-1:0]           stall_cycles,
   output logic                       underflow_err
);

   localparam int                     PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [REG_W-1:0]       ZERO_IDX = REG_W'(ZERO_REG);
   localparam logic [CNT_W_OCC-1:0]   OCC_FULL = CNT_W_OCC'(DEPTH);
   localparam logic [PTR_W-1:0]       PTR_LAST = PTR_W'(DEPTH - 1);

   logic [REG_W-1:0]   entry_rd [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic               full;
   logic               ex_tracked;
   logic               push;
   logic               pop;
   logic [DEPTH-1:0]   entry_live;
   logic [NUM_SRC-1:0] src_hit;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   assign full       = (pending_cnt == OCC_FULL);
   assign ex_tracked = (ex_rd != ZERO_IDX);
   assign ex_hold    = ex_load_valid & ex_tracked & full & ~mem_resp_valid;
   assign push       = ex_load_valid & ex_advance & ~ex_hold & ex_tracked;
   assign pop        = mem_resp_valid & (pending_cnt != '0);

   // An entry is live if its age from the head is below the occupancy; the popping head is
   // excluded because the WB bypass already forwards its data.
   always_comb begin : live_calc
      int age;
      age        = 0;
      entry_live = '0;
      for (int k = 0; k < DEPTH; k++) begin
         age = (k >= int'(rd_ptr)) ? k - int'(rd_ptr) : k + DEPTH - int'(rd_ptr);
         entry_live[k] = (age < int'(pending_cnt)) && !(pop && (age == 0));
      end
   end

   always_comb begin : hit_calc
      logic [REG_W-1:0] rs;
      rs      = '0;
      src_hit = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         rs = id_rs[i*REG_W +: REG_W];
         if (id_rs_used[i] && (rs != ZERO_IDX)) begin
            if (ex_load_valid && (rs == ex_rd)) src_hit[i] = 1'b1;
            for (int k = 0; k < DEPTH; k++) begin
               if (entry_live[k] && (entry_rd[k] == rs)) src_hit[i] = 1'b1;
            end
         end
      end
   end

   assign stall = id_valid & ((|src_hit) | ex_hold);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         pending_cnt   <= '0;
         stall_cycles  <= '0;
         underflow_err <= 1'b0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         if (push && !pop)      pending_cnt <= pending_cnt + 1'b1;
         else if (pop && !push) pending_cnt <= pending_cnt - 1'b1;
         if (stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
         if (mem_resp_valid && (pending_cnt == '0)) underflow_err <= 1'b1;
      end
   end

   // Payload storage carries no reset; validity comes from the pointers and occupancy.
   always_ff @(posedge clk) begin
      if (push) entry_rd[wr_ptr] <= ex_rd;
   end

endmodule
